// File: rtl/lif_hidden_neuron.sv
// Leaky integrate-and-fire neuron fed by a serial stream of input-layer activations.
// Each beat is weighted, integrated with saturation, leaked at end of timestep and thresholded.
module lif_hidden_neuron #(
  parameter int N_INPUTS     = 16,
  parameter int IDX_W        = 4,
  parameter int W_W          = 8,
  parameter int ACC_W        = 20,
  parameter int THRESHOLD    = 1000,
  parameter int LEAK_SHIFT   = 3,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_data,
  input  logic                    i_valid,
  input  logic                    i_last,
  output logic                    o_ready,
  input  logic                    i_w_we,
  input  logic [IDX_W-1:0]        i_w_addr,
  input  logic signed [W_W-1:0]   i_w_data,
  output logic                    o_spike,
  output logic signed [ACC_W-1:0] o_membrane,
  output logic                    o_refrac,
  output logic                    o_overrun
);

  localparam int EXT_W = ACC_W + 2;
  localparam int RC_W  = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  localparam logic signed [EXT_W-1:0] V_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] V_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] THRESH_V = ACC_W'(THRESHOLD);
  localparam logic [RC_W-1:0]         REFRAC_INIT = RC_W'(REFRAC_STEPS);
  localparam logic [IDX_W:0]          IDX_LIMIT = (IDX_W+1)'(N_INPUTS);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EVAL  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic signed [W_W-1:0]   weight_q [N_INPUTS];
  logic [IDX_W:0]          idx_q, idx_d;
  logic signed [ACC_W-1:0] v_q, v_d;
  logic [RC_W-1:0]         refrac_q, refrac_d;
  logic                    spike_q, spike_d;
  logic                    overrun_q, overrun_d;

  logic                    idx_in_range;
  logic signed [W_W-1:0]   weight_sel;
  logic signed [EXT_W-1:0] data_ext;
  logic signed [EXT_W-1:0] weight_ext;
  logic signed [EXT_W-1:0] prod_ext;
  logic signed [EXT_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] sum_sat;
  logic signed [ACC_W-1:0] v_leak;
  logic                    leak_fires;

  // Index one past the table means the upstream sent too many beats; such beats weigh zero.
  assign idx_in_range = (idx_q < IDX_LIMIT);
  assign weight_sel   = idx_in_range ? weight_q[idx_q[IDX_W-1:0]] : '0;

  always_comb begin
    data_ext   = EXT_W'($signed({1'b0, i_data}));
    weight_ext = EXT_W'(weight_sel);
    prod_ext   = data_ext * weight_ext;
    sum_ext    = EXT_W'(v_q) + prod_ext;
    if (sum_ext > V_MAX) begin
      sum_sat = V_MAX[ACC_W-1:0];
    end else if (sum_ext < V_MIN) begin
      sum_sat = V_MIN[ACC_W-1:0];
    end else begin
      sum_sat = sum_ext[ACC_W-1:0];
    end
    v_leak     = v_q - (v_q >>> LEAK_SHIFT);
    leak_fires = (v_leak >= THRESH_V);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    v_d       = v_q;
    refrac_d  = refrac_q;
    spike_d   = 1'b0;
    overrun_d = overrun_q;
    o_ready   = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        o_ready = !i_rst;
        if (i_valid && o_ready) begin
          if (!idx_in_range) begin
            overrun_d = 1'b1;
          end
          if (refrac_q == '0) begin
            v_d = sum_sat;
          end
          if (i_last) begin
            idx_d   = '0;
            state_d = ST_EVAL;
          end else if (idx_in_range) begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_EVAL: begin
        state_d = ST_ACCUM;
        if (refrac_q != '0) begin
          refrac_d = refrac_q - 1'b1;
        end else if (leak_fires) begin
          spike_d  = 1'b1;
          v_d      = '0;
          refrac_d = REFRAC_INIT;
        end else begin
          v_d = v_leak;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_ACCUM;
      idx_q     <= '0;
      v_q       <= '0;
      refrac_q  <= '0;
      spike_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
        weight_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      v_q       <= v_d;
      refrac_q  <= refrac_d;
      spike_q   <= spike_d;
      overrun_q <= overrun_d;
      if (i_w_we) begin
        weight_q[i_w_addr] <= i_w_data;
      end
    end
  end

  assign o_spike    = spike_q;
  assign o_membrane = v_q;
  assign o_refrac   = (refrac_q != '0);
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_lif_hidden_neuron.sv
// Self-checking bench for lif_hidden_neuron: table of timesteps plus hand-written corner sequences,
// with per-timestep expectations queued at the last beat and checked two cycles after acceptance.
module tb_lif_hidden_neuron;

  logic              clk;
  logic              i_rst;
  logic [7:0]        i_data;
  logic              i_valid;
  logic              i_last;
  logic              o_ready;
  logic              i_w_we;
  logic [3:0]        i_w_addr;
  logic signed [7:0] i_w_data;
  logic              o_spike;
  logic signed [19:0] o_membrane;
  logic              o_refrac;
  logic              o_overrun;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    bit                doReset;
    logic signed [7:0] weight;
    logic [7:0]        data;
    int                nBeats;
    bit                expSpike;
    int                expMembrane;
    bit                expRefrac;
    bit                expOverrun;
  } step_t;

  typedef struct {
    bit spike;
    int membrane;
    bit refrac;
    bit overrun;
  } exp_t;

  exp_t sbQueue[$];
  bit   pend1 = 0;
  bit   pend2 = 0;

  lif_hidden_neuron dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_last     (i_last),
    .o_ready    (o_ready),
    .i_w_we     (i_w_we),
    .i_w_addr   (i_w_addr),
    .i_w_data   (i_w_data),
    .o_spike    (o_spike),
    .o_membrane (o_membrane),
    .o_refrac   (o_refrac),
    .o_overrun  (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: a last beat accepted in cycle t is reflected on the outputs in cycle t+2.
  always @(negedge clk) begin
    if (i_rst) begin
      pend1 = 0;
      pend2 = 0;
    end else begin
      if (pend2) begin
        if (sbQueue.size() == 0) begin
          checkOutput("scoreboard_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sbQueue.pop_front();
          checkOutput("spike", longint'(o_spike), longint'(e.spike));
          checkOutput("membrane", longint'(o_membrane), longint'(e.membrane));
          checkOutput("refrac", longint'(o_refrac), longint'(e.refrac));
          checkOutput("overrun", longint'(o_overrun), longint'(e.overrun));
        end
      end else begin
        checkOutput("no_spurious_spike", longint'(o_spike), 0);
      end
      pend2 = pend1;
      pend1 = i_valid && o_ready && i_last;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // All driving tasks start and end just after a rising edge.
  task automatic applyStimulus(input logic [7:0] data, input bit last, input bit we,
                               input logic [3:0] addr, input logic signed [7:0] wdata,
                               output int waited);
    i_valid  = 1'b1;
    i_data   = data;
    i_last   = last;
    i_w_we   = we;
    i_w_addr = addr;
    i_w_data = wdata;
    waited   = 0;
    @(negedge clk);
    while (!o_ready && waited < 10) begin
      waited++;
      @(negedge clk);
    end
    if (!o_ready) checkOutput("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_w_we  = 1'b0;
  endtask

  task automatic writeWeight(input logic [3:0] addr, input logic signed [7:0] wdata);
    i_w_we   = 1'b1;
    i_w_addr = addr;
    i_w_data = wdata;
    @(posedge clk);
    #1;
    i_w_we = 1'b0;
  endtask

  task automatic writeAllWeights(input logic signed [7:0] wdata);
    for (int a = 0; a < 16; a++) writeWeight(4'(a), wdata);
  endtask

  task automatic pushExpect(input bit spike, input int membrane, input bit refrac, input bit overrun);
    exp_t e;
    e.spike    = spike;
    e.membrane = membrane;
    e.refrac   = refrac;
    e.overrun  = overrun;
    sbQueue.push_back(e);
  endtask

  task automatic runTimestep(input logic [7:0] data, input int nBeats, input exp_t e);
    int w;
    for (int b = 0; b < nBeats; b++) begin
      if (b == nBeats - 1) pushExpect(e.spike, e.membrane, e.refrac, e.overrun);
      applyStimulus(data, b == nBeats - 1, 1'b0, 4'd0, 8'sd0, w);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, longint'(o_ready), 1);
    checkOutput({tag, "_membrane"}, longint'(o_membrane), 0);
    checkOutput({tag, "_spike"}, longint'(o_spike), 0);
    checkOutput({tag, "_refrac"}, longint'(o_refrac), 0);
    checkOutput({tag, "_overrun"}, longint'(o_overrun), 0);
  endtask

  task automatic applyReset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_w_we  = 1'b0;
    sbQueue.delete();
    @(negedge clk);
    checkOutput("ready_in_reset", longint'(o_ready), 0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    #1;
    checkResetState("after_reset");
  endtask

  step_t steps[10];

  initial begin
    exp_t e;
    int   w;
    bit   haveWeight;
    logic signed [7:0] curWeight;

    i_rst = 1'b1; i_data = '0; i_valid = 1'b0; i_last = 1'b0;
    i_w_we = 1'b0; i_w_addr = '0; i_w_data = '0;

    steps[0] = '{1, 8'sd10,   8'd8,   16, 1, 0,       1, 0};
    steps[1] = '{0, 8'sd10,   8'd8,   16, 0, 0,       1, 0};
    steps[2] = '{0, 8'sd10,   8'd8,   16, 0, 0,       0, 0};
    steps[3] = '{0, 8'sd10,   8'd8,   16, 1, 0,       1, 0};
    steps[4] = '{1, 8'sd10,   8'd5,   16, 0, 700,     0, 0};
    steps[5] = '{0, 8'sd10,   8'd5,   16, 1, 0,       1, 0};
    steps[6] = '{1, -8'sd128, 8'd255, 16, 0, -456960, 0, 0};
    steps[7] = '{0, -8'sd128, 8'd255, 16, 0, -458752, 0, 0};
    steps[8] = '{1, 8'sd10,   8'd1,   20, 0, 140,     0, 1};
    steps[9] = '{0, 8'sd10,   8'd1,   16, 0, 263,     0, 1};

    repeat (2) @(posedge clk);
    #1;
    applyReset();
    haveWeight = 0;
    curWeight  = '0;

    for (int s = 0; s < 10; s++) begin
      if (steps[s].doReset) begin
        applyReset();
        haveWeight = 0;
      end
      if (!haveWeight || curWeight != steps[s].weight) begin
        writeAllWeights(steps[s].weight);
        curWeight  = steps[s].weight;
        haveWeight = 1;
      end
      e = '{steps[s].expSpike, steps[s].expMembrane, steps[s].expRefrac, steps[s].expOverrun};
      runTimestep(steps[s].data, steps[s].nBeats, e);
    end

    // Reset in the middle of a timestep wipes the partial sum and the weight table.
    applyReset();
    writeAllWeights(8'sd10);
    for (int b = 0; b < 7; b++) applyStimulus(8'd8, 1'b0, 1'b0, 4'd0, 8'sd0, w);
    applyReset();
    runTimestep(8'd8, 16, '{0, 0, 0, 0});

    // A beat held valid through EVAL is accepted exactly one cycle later and not lost.
    applyReset();
    writeAllWeights(8'sd10);
    for (int b = 0; b < 16; b++) begin
      if (b == 15) pushExpect(0, 700, 0, 0);
      applyStimulus(8'd5, b == 15, 1'b0, 4'd0, 8'sd0, w);
    end
    applyStimulus(8'd5, 1'b0, 1'b0, 4'd0, 8'sd0, w);
    checkOutput("eval_hold_wait_cycles", longint'(w), 1);
    for (int b = 1; b < 16; b++) begin
      if (b == 15) pushExpect(1, 0, 1, 0);
      applyStimulus(8'd5, b == 15, 1'b0, 4'd0, 8'sd0, w);
    end

    // A weight written in the same cycle as its read uses the old value; the new one applies later.
    applyReset();
    writeAllWeights(8'sd10);
    applyStimulus(8'd5, 1'b0, 1'b1, 4'd0, 8'sd100, w);
    for (int b = 1; b < 16; b++) begin
      if (b == 15) pushExpect(0, 700, 0, 0);
      applyStimulus(8'd5, b == 15, 1'b0, 4'd0, 8'sd0, w);
    end
    runTimestep(8'd1, 16, '{0, 832, 0, 0});

    begin
      int guard = 0;
      while ((sbQueue.size() != 0 || pend1 || pend2) && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      if (sbQueue.size() != 0) checkOutput("scoreboard_drain", longint'(sbQueue.size()), 0);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
